// File: rtl/deserialization_ss_if.sv
// Parallel I/Q output bus of the serial-link receiver.
// The master drives the word, the slave returns dataReady.
interface deserialization_ss_if #(
  parameter int ACC_DATA_WIDTH = 16
) ();
  logic                      dataValid;
  logic                      dataReady;
  logic [ACC_DATA_WIDTH-1:0] dataI;
  logic [ACC_DATA_WIDTH-1:0] dataQ;

  modport master (
    output dataValid,
    output dataI,
    output dataQ,
    input  dataReady
  );

  modport slave (
    input  dataValid,
    input  dataI,
    input  dataQ,
    output dataReady
  );
endinterface

// File: rtl/deserialization_ss.sv
// Serial-link receiver: rebuilds the {Q,I} word sent LSB first
// and offers it as parallel I/Q samples over valid/ready.
module deserialization_ss #(
  parameter int ACC_DATA_WIDTH = 16,
  parameter int CNT_WIDTH      = 6
) (
  input  logic serialClk,
  input  logic resetN,
  input  logic serialStart,
  input  logic serialIn,
  deserialization_ss_if.master out_if,
  output logic busy,
  output logic frameError,
  output logic overrun
);

  localparam int FW = 2 * ACC_DATA_WIDTH;
  localparam int IW = $clog2(FW);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    COMMIT
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [FW-1:0]             shift_q, shift_d;
  logic                      valid_q, valid_d;
  logic [ACC_DATA_WIDTH-1:0] i_q, i_d;
  logic [ACC_DATA_WIDTH-1:0] q_q, q_d;
  logic                      fe_q, fe_d;
  logic                      ov_q, ov_d;
  logic                      commit;
  logic                      accept;

  assign commit = (state_q == COMMIT);
  assign accept = valid_q && out_if.dataReady;

  always_ff @(posedge serialClk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      i_q     <= i_d;
      q_q     <= q_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  // A start strobe in COMMIT is a back-to-back frame, not an error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (serialStart) begin
          shift_d = FW'(serialIn);
          cnt_d   = CNT_WIDTH'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (serialStart) begin
          fe_d    = 1'b1;
          shift_d = FW'(serialIn);
          cnt_d   = CNT_WIDTH'(1);
        end else begin
          shift_d[cnt_q[IW-1:0]] = serialIn;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == LAST) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (serialStart) begin
          shift_d = FW'(serialIn);
          cnt_d   = CNT_WIDTH'(1);
          state_d = RECV;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output register: a full, unaccepted word wins over a new one.
  always_comb begin
    valid_d = valid_q;
    i_d     = i_q;
    q_d     = q_q;
    ov_d    = 1'b0;
    if (commit) begin
      if (valid_q && !out_if.dataReady) begin
        ov_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        i_d     = shift_q[ACC_DATA_WIDTH-1:0];
        q_d     = shift_q[FW-1:ACC_DATA_WIDTH];
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  assign out_if.dataValid = valid_q;
  assign out_if.dataI     = i_q;
  assign out_if.dataQ     = q_q;
  assign busy             = (state_q != IDLE);
  assign frameError       = fe_q;
  assign overrun          = ov_q;

endmodule
